// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back unit.
// Optional feature macro: WB_RETIRE_CNT_EN (retired-operation counter on wb_unit).
package wb_pkg;

  // Top-level control states of the write-back unit.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // RV32I load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Width of a counter able to hold the values 0 .. timeout-1.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Execute/memory/register-file bundle seen by the write-back unit.
// slave: the write-back unit; master: execute, data memory and register-file side.
interface wb_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // execute -> write-back
  logic              ex_valid;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_wr;
  logic              ex_is_load;
  logic [2:0]        ex_funct3;
  logic [DATA_W-1:0] ex_result;
  // data memory response
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  // register-file write port and status
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              write_back_en;
  logic              load_err;
  logic              busy;

  modport slave (
    input  ex_valid, ex_rd, ex_reg_wr, ex_is_load, ex_funct3, ex_result,
    input  mem_rsp_valid, mem_rsp_data,
    output ex_ready, wr_addr, wr_data, write_back_en, load_err, busy
  );

  modport master (
    output ex_valid, ex_rd, ex_reg_wr, ex_is_load, ex_funct3, ex_result,
    output mem_rsp_valid, mem_rsp_data,
    input  ex_ready, wr_addr, wr_data, write_back_en, load_err, busy
  );
endinterface

// File: rtl/wb_unit_load_extend.sv
// Load data extraction: picks the byte/halfword/word addressed by the low
// address bits out of an aligned memory word and sign/zero extends it.
// Flags unknown funct3 values and misaligned halfword/word accesses.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o,
  output logic              illegal_o
);

  logic [7:0]  bytes_w  [4];
  logic [15:0] halves_w [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the low 32 bits of the word into byte and halfword lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign bytes_w[gi] = word_i[8*gi +: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_halves
    assign halves_w[gi] = word_i[16*gi +: 16];
  end

  // Halfword lane is chosen by offset bit 1; offset bit 0 only matters for legality.
  assign byte_sel = bytes_w[offset_i];
  assign half_sel = halves_w[offset_i[1]];

  // Decode load type into extended data and a legality flag.
  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o    = {{(DATA_W-16){half_sel[15]}}, half_sel};
        illegal_o = offset_i[0];
      end
      F3_LHU: begin
        data_o    = {{(DATA_W-16){1'b0}}, half_sel};
        illegal_o = offset_i[0];
      end
      F3_LW: begin
        data_o    = word_i;
        illegal_o = (offset_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: retires ALU results one cycle after acceptance and loads
// after a variable-latency memory response, issuing exactly one register-file
// write strobe per retiring write. Loads that never get a response are aborted
// after TIMEOUT cycles with a load_err pulse.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_cnt output.
module wb_unit
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_unit_if.slave    bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              reg_wr_q, reg_wr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wb_en_q, wb_en_d;
  logic              load_err_q, load_err_d;

  logic [DATA_W-1:0] ext_data;
  logic              ext_illegal;

  // Extraction always works on the latched load context and the live response word.
  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .funct3_i  (funct3_q),
    .offset_i  (offset_q),
    .word_i    (bus.mem_rsp_data),
    .data_o    (ext_data),
    .illegal_o (ext_illegal)
  );

  // Next-state and write-port decisions; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    reg_wr_d   = reg_wr_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wb_en_d    = 1'b0;
    load_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!bus.ex_is_load) begin
            if (bus.ex_reg_wr && (bus.ex_rd != '0)) begin
              wb_en_d   = 1'b1;
              wr_addr_d = bus.ex_rd;
              wr_data_d = bus.ex_result;
            end
          end else begin
            rd_d     = bus.ex_rd;
            reg_wr_d = bus.ex_reg_wr;
            funct3_d = bus.ex_funct3;
            offset_d = bus.ex_result[1:0];
            cnt_d    = '0;
            state_d  = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the timeout cycle still completes the load.
        if (bus.mem_rsp_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (ext_illegal) begin
            load_err_d = 1'b1;
          end else if (reg_wr_q && (rd_q != '0)) begin
            wb_en_d   = 1'b1;
            wr_addr_d = rd_q;
            wr_data_d = ext_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          load_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, load context and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wb_en_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      reg_wr_q   <= reg_wr_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wb_en_q    <= wb_en_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.ex_ready      = (state_q == IDLE);
  assign bus.busy          = (state_q == WAIT_MEM);
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.write_back_en = wb_en_q;
  assign bus.load_err      = load_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic        retire_inc;

  // Completed operations: every accepted non-load, and every legal load response
  // (including those whose write is suppressed by rd=0 or !reg_wr).
  assign retire_inc = ((state_q == IDLE) && bus.ex_valid && !bus.ex_is_load) ||
                      ((state_q == WAIT_MEM) && bus.mem_rsp_valid && !ext_illegal);

  // Free-running retire counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (retire_inc) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the write-back rules.
`timescale 1ns/1ps
module tb_wb_unit;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  wb_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_wait;
  int          m_waited;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [4:0]  m_rd;
  bit          m_wr;
  bit          exp_wb, exp_err;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] exp_cnt;

  // Returns 1 and the loaded value for a legal load, 0 otherwise.
  function automatic bit ref_load(input logic [2:0] f3, input int off,
                                  input logic [31:0] word, output logic [31:0] val);
    logic [31:0] v;
    val = 32'h0;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (off * 8)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        val = v;
        return 1'b1;
      end
      3'd1, 3'd5: begin
        if (off % 2 != 0) return 1'b0;
        v = (word >> (off * 8)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        val = v;
        return 1'b1;
      end
      3'd2: begin
        val = word;
        return (off == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] v;
    bit ok;
    if (!rst_n) begin
      m_wait = 0; m_waited = 0; exp_wb = 0; exp_err = 0;
      exp_addr = '0; exp_data = '0; exp_cnt = '0;
    end else begin
      exp_wb = 0; exp_err = 0;
      if (!m_wait) begin
        if (bus.ex_valid) begin
          if (!bus.ex_is_load) begin
            exp_cnt++;
            if (bus.ex_reg_wr && bus.ex_rd != 0) begin
              exp_wb = 1; exp_addr = bus.ex_rd; exp_data = bus.ex_result;
            end
          end else begin
            m_wait = 1; m_waited = 0;
            m_f3 = bus.ex_funct3; m_off = bus.ex_result[1:0];
            m_rd = bus.ex_rd; m_wr = bus.ex_reg_wr;
          end
        end
      end else begin
        m_waited++;
        if (bus.mem_rsp_valid) begin
          m_wait = 0;
          ok = ref_load(m_f3, int'(m_off), bus.mem_rsp_data, v);
          if (!ok) exp_err = 1;
          else begin
            exp_cnt++;
            if (m_wr && m_rd != 0) begin
              exp_wb = 1; exp_addr = m_rd; exp_data = v;
            end
          end
        end else if (m_waited == TIMEOUT) begin
          m_wait = 0; exp_err = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp("m_wb_en",   32'(bus.write_back_en), 32'(exp_wb));
      cmp("m_err",     32'(bus.load_err),      32'(exp_err));
      cmp("m_addr",    32'(bus.wr_addr),       32'(exp_addr));
      cmp("m_data",    bus.wr_data,            exp_data);
      cmp("m_ready",   32'(bus.ex_ready),      32'(!m_wait));
      cmp("m_busy",    32'(bus.busy),          32'(m_wait));
`ifdef WB_RETIRE_CNT_EN
      cmp("m_retire",  retire_cnt,             exp_cnt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_drive();
    @(posedge clk); #2;
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic drive_op(input bit ld, input bit wr, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [31:0] res);
    bus.ex_valid = 1; bus.ex_is_load = ld; bus.ex_reg_wr = wr;
    bus.ex_rd = rd; bus.ex_funct3 = f3; bus.ex_result = res;
    @(posedge clk); #2;
    bus.ex_valid = 0;
  endtask

  // Presents a response in the n_wait-th wait cycle; returns after the completion edge.
  task automatic respond(input int n_wait, input logic [31:0] data);
    for (int i = 1; i < n_wait; i++) begin
      @(negedge clk);
      cmp("wait_ready", 32'(bus.ex_ready), 32'd0);
      cmp("wait_busy",  32'(bus.busy),     32'd1);
      to_drive();
    end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = data;
    @(posedge clk); #2;
    bus.mem_rsp_valid = 0;
  endtask

  logic [2:0] f3_tab [5];

  initial begin
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
    rst_n = 0;
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_reg_wr = 0; bus.ex_rd = '0;
    bus.ex_funct3 = '0; bus.ex_result = '0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk_en = 1;

    // reset state
    @(negedge clk);
    cmp("rst_wb",    32'(bus.write_back_en), 32'd0);
    cmp("rst_addr",  32'(bus.wr_addr),       32'd0);
    cmp("rst_data",  bus.wr_data,            32'd0);
    cmp("rst_err",   32'(bus.load_err),      32'd0);
    cmp("rst_ready", 32'(bus.ex_ready),      32'd1);
    to_drive();

    // ALU op, one-cycle latency and single-cycle strobe
    drive_op(0, 1, 5'd5, 3'd0, 32'h1234_5678);
    @(negedge clk);
    cmp("alu_wb",   32'(bus.write_back_en), 32'd1);
    cmp("alu_addr", 32'(bus.wr_addr),       32'd5);
    cmp("alu_data", bus.wr_data,            32'h1234_5678);
    to_drive();
    @(negedge clk);
    cmp("alu_wb_off", 32'(bus.write_back_en), 32'd0);
    to_drive();

    // LB offset 3, response after 4 cycles
    drive_op(1, 1, 5'd7, 3'd0, 32'h0000_1003);
    respond(4, 32'h80FF_0011);
    @(negedge clk);
    cmp("lb_wb",   32'(bus.write_back_en), 32'd1);
    cmp("lb_addr", 32'(bus.wr_addr),       32'd7);
    cmp("lb_data", bus.wr_data,            32'hFFFF_FF80);
    cmp("lb_err",  32'(bus.load_err),      32'd0);
    to_drive();

    // LHU offset 2
    drive_op(1, 1, 5'd10, 3'd5, 32'h0000_2002);
    respond(2, 32'h8001_FFFF);
    @(negedge clk);
    cmp("lhu_wb",   32'(bus.write_back_en), 32'd1);
    cmp("lhu_data", bus.wr_data,            32'h0000_8001);
    to_drive();

    // LH offset 1 -> misaligned
    drive_op(1, 1, 5'd11, 3'd1, 32'h0000_2001);
    respond(1, 32'h1234_5678);
    @(negedge clk);
    cmp("lh_mis_err", 32'(bus.load_err),      32'd1);
    cmp("lh_mis_wb",  32'(bus.write_back_en), 32'd0);
    to_drive();
    @(negedge clk);
    cmp("lh_mis_err_off", 32'(bus.load_err), 32'd0);
    to_drive();

    // timeout, then a late response is ignored
    drive_op(1, 1, 5'd12, 3'd2, 32'h0000_0000);
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    cmp("to_err",   32'(bus.load_err),      32'd1);
    cmp("to_wb",    32'(bus.write_back_en), 32'd0);
    cmp("to_ready", 32'(bus.ex_ready),      32'd1);
    to_drive();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hAAAA_AAAA;
    to_drive();
    bus.mem_rsp_valid = 0;
    @(negedge clk);
    cmp("late_wb",   32'(bus.write_back_en), 32'd0);
    cmp("late_err",  32'(bus.load_err),      32'd0);
    cmp("late_addr", 32'(bus.wr_addr),       32'd10);
    to_drive();

    // response in the timeout cycle wins
    drive_op(1, 1, 5'd9, 3'd2, 32'h0000_0040);
    respond(TIMEOUT, 32'hDEAD_BEEF);
    @(negedge clk);
    cmp("edge_wb",   32'(bus.write_back_en), 32'd1);
    cmp("edge_data", bus.wr_data,            32'hDEAD_BEEF);
    cmp("edge_err",  32'(bus.load_err),      32'd0);
    to_drive();

    // rd=0 writes are suppressed but still retire
    drive_op(0, 1, 5'd0, 3'd0, 32'h5555_5555);
    @(negedge clk);
    cmp("rd0_alu_wb", 32'(bus.write_back_en), 32'd0);
    to_drive();
    drive_op(1, 1, 5'd0, 3'd2, 32'h0000_0080);
    respond(3, 32'h7777_7777);
    @(negedge clk);
    cmp("rd0_lw_wb",  32'(bus.write_back_en), 32'd0);
    cmp("rd0_lw_err", 32'(bus.load_err),      32'd0);
`ifdef WB_RETIRE_CNT_EN
    cmp("retire_lit", retire_cnt, 32'd6);
`endif
    to_drive();

    // reset during WAIT_MEM
    drive_op(1, 1, 5'd13, 3'd2, 32'h0000_0000);
    to_drive();
    rst_n = 0;
    #1;
    cmp("mid_rst_wb",   32'(bus.write_back_en), 32'd0);
    cmp("mid_rst_addr", 32'(bus.wr_addr),       32'd0);
    cmp("mid_rst_data", bus.wr_data,            32'd0);
    cmp("mid_rst_err",  32'(bus.load_err),      32'd0);
    cmp("mid_rst_busy", 32'(bus.busy),          32'd0);
    to_drive();
    rst_n = 1;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1111_1111;
    to_drive();
    bus.mem_rsp_valid = 0;
    @(negedge clk);
    cmp("post_rst_wb",    32'(bus.write_back_en), 32'd0);
    cmp("post_rst_ready", 32'(bus.ex_ready),      32'd1);
    to_drive();

    // randomized traffic, checked by the per-cycle model compare
    for (int c = 0; c < 4000; c++) begin
      bus.ex_valid   = ($urandom_range(0, 1) == 1);
      bus.ex_is_load = ($urandom_range(0, 1) == 1);
      bus.ex_reg_wr  = ($urandom_range(0, 4) != 0);
      bus.ex_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.ex_funct3  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                                   : f3_tab[$urandom_range(0, 4)];
      bus.ex_result  = $urandom;
      if ($urandom_range(0, 1) == 1) bus.ex_result[1:0] = 2'b00;
      bus.mem_rsp_valid = ($urandom_range(0, 99) < 15);
      bus.mem_rsp_data  = $urandom;
      to_drive();
    end
    bus.ex_valid = 0; bus.mem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
